sao_lcu_feeder: RTL and testbench

SAO_LCU_FEEDER -- requirements
Module: sao_lcu_feeder

---
 rtl/sao_lcu_feeder_if.sv | 36 +++
 rtl/sao_lcu_feeder.sv | 158 +++++++++++++++
 tb/tb_sao_lcu_feeder.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sao_lcu_feeder_if.sv
// Frame-memory, parameter-table and downstream SAO-stage signals of the LCU feeder.
// master = feeder side, slave = memories plus SAO stage.
interface sao_lcu_feeder_if #(
    parameter int FRAME_LOG2 = 7
);
    logic                      pix_rd;
    logic [2*FRAME_LOG2-1:0]   pix_addr;
    logic [7:0]                pix_q;
    logic                      par_rd;
    logic [5:0]                par_addr;
    logic [23:0]               par_q;
    logic                      in_en;
    logic [7:0]                din;
    logic [1:0]                sao_type;
    logic [4:0]                sao_band_pos;
    logic                      sao_eo_class;
    logic [15:0]               sao_offset;
    logic [2:0]                lcu_x;
    logic [2:0]                lcu_y;
    logic [1:0]                lcu_size;
    logic                      busy;

    modport master (
        output pix_rd, pix_addr, par_rd, par_addr,
        output in_en, din, sao_type, sao_band_pos, sao_eo_class, sao_offset,
        output lcu_x, lcu_y, lcu_size,
        input  pix_q, par_q, busy
    );

    modport slave (
        input  pix_rd, pix_addr, par_rd, par_addr,
        input  in_en, din, sao_type, sao_band_pos, sao_eo_class, sao_offset,
        input  lcu_x, lcu_y, lcu_size,
        output pix_q, par_q, busy
    );
endinterface

// File: rtl/sao_lcu_feeder.sv
// Streams a square frame LCU by LCU to an SAO stage, fetching each LCU's SAO parameters first.
// Optional STREAM_CSUM_EN: accumulate a 16-bit checksum of every delivered pixel on csum.
module sao_lcu_feeder #(
    parameter int FRAME_LOG2 = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       lcu_size_cfg,
    sao_lcu_feeder_if.master bus,
    output logic             done,
    output logic [15:0]      csum
);
    localparam int W = 1 << FRAME_LOG2;

    typedef enum logic [2:0] {IDLE, PARAM, PLOAD, STREAM, DRAIN, WAIT, DONE} state_t;

    state_t                state, state_nxt;
    logic [1:0]            size_sel;
    logic [2:0]            cur_x, cur_y;
    logic [2:0]            lcu_x_q, lcu_y_q;
    logic [1:0]            lcu_size_q;
    logic [23:0]           par_r;
    logic [5:0]            px, py;
    logic                  ret_valid, hold_valid, wait_done;
    logic [7:0]            hold;

    logic [2:0]            nlog, nl_log, nl_m1;
    logic [5:0]            n_m1, par_idx;
    logic [FRAME_LOG2-1:0] x_pos, y_pos;
    logic                  issue, deliver, last_pix, last_lcu;

    // Geometry: LCU edge is 2^nlog, NL = W / N LCUs per row, addresses built from shifts.
    always_comb begin
        nlog   = 3'd4 + {1'b0, size_sel};
        nl_log = 3'(FRAME_LOG2) - nlog;
        nl_m1  = 3'((W >> nlog) - 1);
        case (size_sel)
            2'd0:    n_m1 = 6'd15;
            2'd1:    n_m1 = 6'd31;
            default: n_m1 = 6'd63;
        endcase
        par_idx = 6'(({3'd0, cur_y} << nl_log) | {3'd0, cur_x});
        x_pos   = FRAME_LOG2'(({7'd0, lcu_x_q} << nlog) | {4'd0, px});
        y_pos   = FRAME_LOG2'(({7'd0, lcu_y_q} << nlog) | {4'd0, py});
    end

    assign issue    = (state == STREAM) && !bus.busy;
    assign deliver  = (ret_valid || hold_valid) && !bus.busy;
    assign last_pix = (px == n_m1) && (py == n_m1);
    assign last_lcu = (cur_x == nl_m1) && (cur_y == nl_m1);

    assign bus.pix_rd       = issue;
    assign bus.pix_addr     = {y_pos, x_pos};
    assign bus.par_rd       = (state == PARAM);
    assign bus.par_addr     = par_idx;
    assign bus.in_en        = deliver;
    assign bus.din          = !deliver ? 8'd0 : (hold_valid ? hold : bus.pix_q);
    assign bus.sao_type     = par_r[23:22];
    assign bus.sao_band_pos = par_r[21:17];
    assign bus.sao_eo_class = par_r[16];
    assign bus.sao_offset   = par_r[15:0];
    assign bus.lcu_x        = lcu_x_q;
    assign bus.lcu_y        = lcu_y_q;
    assign bus.lcu_size     = lcu_size_q;
    assign done             = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = PARAM;
            PARAM:   state_nxt = PLOAD;
            PLOAD:   state_nxt = STREAM;
            STREAM:  if (issue && last_pix) state_nxt = DRAIN;
            DRAIN:   if (deliver) state_nxt = WAIT;
            WAIT:    if (wait_done && !bus.busy) state_nxt = last_lcu ? DONE : PARAM;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A return that meets a stall parks in hold; no read issues while stalled, so hold and a
    // fresh return never coincide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            size_sel   <= 2'd0;
            cur_x      <= 3'd0;
            cur_y      <= 3'd0;
            lcu_x_q    <= 3'd0;
            lcu_y_q    <= 3'd0;
            lcu_size_q <= 2'd0;
            par_r      <= 24'd0;
            px         <= 6'd0;
            py         <= 6'd0;
            ret_valid  <= 1'b0;
            hold_valid <= 1'b0;
            hold       <= 8'd0;
            wait_done  <= 1'b0;
        end else begin
            ret_valid <= issue;
            if (ret_valid && bus.busy) begin
                hold       <= bus.pix_q;
                hold_valid <= 1'b1;
            end else if (hold_valid && !bus.busy) begin
                hold_valid <= 1'b0;
            end
            wait_done <= (state == WAIT);
            case (state)
                IDLE: if (start) begin
                    size_sel <= (lcu_size_cfg == 2'd3) ? 2'd2 : lcu_size_cfg;
                    cur_x    <= 3'd0;
                    cur_y    <= 3'd0;
                end
                PLOAD: begin
                    par_r      <= bus.par_q;
                    lcu_x_q    <= cur_x;
                    lcu_y_q    <= cur_y;
                    lcu_size_q <= size_sel;
                    px         <= 6'd0;
                    py         <= 6'd0;
                end
                STREAM: if (issue) begin
                    if (px == n_m1) begin
                        px <= 6'd0;
                        py <= py + 6'd1;
                    end else begin
                        px <= px + 6'd1;
                    end
                end
                WAIT: if (wait_done && !bus.busy && !last_lcu) begin
                    if (cur_x == nl_m1) begin
                        cur_x <= 3'd0;
                        cur_y <= cur_y + 3'd1;
                    end else begin
                        cur_x <= cur_x + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef STREAM_CSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                      csum <= 16'd0;
        else if (state == IDLE && start) csum <= 16'd0;
        else if (deliver)               csum <= csum + {8'd0, bus.din};
    end
`else
    assign csum = 16'd0;
`endif

endmodule

// File: tb/tb_sao_lcu_feeder.sv
// Directed self-checking bench for sao_lcu_feeder: frame order, parameter fetch, stalls,
// mid-frame reset, checksum and ignored start.
module tb_sao_lcu_feeder;
    localparam int FL = 7;
    localparam int W  = 128;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  lcu_size_cfg;
    logic        done;
    logic [15:0] csum;

    sao_lcu_feeder_if #(.FRAME_LOG2(FL)) bus ();

    sao_lcu_feeder #(.FRAME_LOG2(FL)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .lcu_size_cfg (lcu_size_cfg),
        .bus          (bus.master),
        .done         (done),
        .csum         (csum)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    logic data_ff = 1'b0;
    int   nlog_tb = 6;
    logic mon_rst = 1'b1;

    function automatic logic [23:0] par_entry(input logic [5:0] k);
        logic [15:0] off;
        off = 16'(k) * 16'd257;
        return {k[1:0], k[4:0], k[0], off};
    endfunction

    // Memory models: one-cycle read latency, junk on the bus when nothing was read.
    always @(posedge clk) begin
        bus.pix_q <= bus.pix_rd ? (data_ff ? 8'hFF : bus.pix_addr[7:0]) : 8'h5A;
        bus.par_q <= par_entry(bus.par_addr);
    end

    int en_cnt, par_cnt, done_cnt, ord_err, lcu_err, sao_err, par_err, en_busy_err;
    int cyc = 0, last_en_cyc, done_cyc;
    int mn, mper, mlcu, mw, mnl, mex, mey, mea;
    logic [7:0] exp_din;
    logic [7:0] first_din [0:64];

    // Reference order: k-th pixel of the frame derived from LCU/row/column arithmetic.
    always @(negedge clk) begin
        if (mon_rst) begin
            en_cnt = 0; par_cnt = 0; done_cnt = 0; ord_err = 0; lcu_err = 0;
            sao_err = 0; par_err = 0; en_busy_err = 0; last_en_cyc = 0; done_cyc = 0;
        end else begin
            if (bus.in_en && bus.busy) en_busy_err++;
            if (bus.in_en) begin
                mn   = 1 << nlog_tb;
                mper = mn * mn;
                mlcu = en_cnt / mper;
                mw   = en_cnt % mper;
                mnl  = W / mn;
                mex  = mlcu % mnl;
                mey  = mlcu / mnl;
                mea  = (mey * mn + mw / mn) * W + mex * mn + mw % mn;
                exp_din = data_ff ? 8'hFF : 8'(mea);
                if (bus.din !== exp_din) ord_err++;
                if (bus.lcu_x !== 3'(mex) || bus.lcu_y !== 3'(mey) || bus.lcu_size !== 2'(nlog_tb - 4))
                    lcu_err++;
                if ({bus.sao_type, bus.sao_band_pos, bus.sao_eo_class, bus.sao_offset} !== par_entry(6'(mlcu)))
                    sao_err++;
                if (en_cnt < 65) first_din[en_cnt] = bus.din;
                en_cnt++;
                last_en_cyc = cyc;
            end
            if (bus.par_rd) begin
                if (bus.par_addr !== 6'(par_cnt)) par_err++;
                par_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        cyc++;
    end

    task automatic clear_mon();
        mon_rst = 1'b1;
        @(negedge clk);
        #1 mon_rst = 1'b0;
    endtask

    task automatic pulse_start(input logic [1:0] cfg);
        @(negedge clk);
        lcu_size_cfg = cfg;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_until_done(input int limit, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done) begin
                timed_out = 1'b0;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({bus.pix_rd, bus.par_rd, bus.in_en, done} !== 4'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_strobes: got %b, expected 0000", {bus.pix_rd, bus.par_rd, bus.in_en, done});
        end
        tests_run++;
        if ({bus.pix_addr, bus.par_addr, bus.din, csum} !== 44'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_buses: got %h, expected 0", {bus.pix_addr, bus.par_addr, bus.din, csum});
        end
        tests_run++;
        if ({bus.sao_type, bus.sao_band_pos, bus.sao_eo_class, bus.sao_offset, bus.lcu_x, bus.lcu_y, bus.lcu_size} !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_params: got %h, expected 0",
                     {bus.sao_type, bus.sao_band_pos, bus.sao_eo_class, bus.sao_offset, bus.lcu_x, bus.lcu_y, bus.lcu_size});
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        tests_run++;
        if ({bus.pix_rd, bus.par_rd} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL idle_no_start: got %b, expected 00", {bus.pix_rd, bus.par_rd});
        end
    endtask

    task automatic test_frame_64();
        bit to;
        nlog_tb = 6;
        data_ff = 1'b0;
        clear_mon();
        pulse_start(2'd2);
        run_until_done(20000, to);
        tests_run++;
        if (to) begin tests_failed++; $display("[TB] FAIL f64_timeout: done not seen within 20000 cycles"); end
        tests_run++;
        if (en_cnt != 16384) begin tests_failed++; $display("[TB] FAIL f64_count: got %0d, expected 16384", en_cnt); end
        tests_run++;
        if (ord_err != 0) begin tests_failed++; $display("[TB] FAIL f64_order: got %0d bad pixels, expected 0", ord_err); end
        tests_run++;
        if (lcu_err != 0) begin tests_failed++; $display("[TB] FAIL f64_lcu_pos: got %0d bad, expected 0", lcu_err); end
        for (int i = 0; i < 64; i++) begin
            tests_run++;
            if (first_din[i] !== 8'(i)) begin
                tests_failed++;
                $display("[TB] FAIL f64_din%0d: got %0d, expected %0d", i, first_din[i], i);
            end
        end
        tests_run++;
        if (first_din[64] !== 8'd128) begin tests_failed++; $display("[TB] FAIL f64_din64: got %0d, expected 128", first_din[64]); end
        tests_run++;
        if (done_cnt != 1) begin tests_failed++; $display("[TB] FAIL f64_done_pulses: got %0d, expected 1", done_cnt); end
        tests_run++;
        if (done_cyc - last_en_cyc != 3) begin
            tests_failed++;
            $display("[TB] FAIL f64_done_gap: got %0d, expected 3", done_cyc - last_en_cyc);
        end
        tests_run++;
        if (par_cnt != 4) begin tests_failed++; $display("[TB] FAIL f64_par_reads: got %0d, expected 4", par_cnt); end
    endtask

    task automatic test_params_16();
        bit to;
        nlog_tb = 4;
        data_ff = 1'b0;
        clear_mon();
        pulse_start(2'd0);
        run_until_done(20000, to);
        tests_run++;
        if (to) begin tests_failed++; $display("[TB] FAIL p16_timeout: done not seen within 20000 cycles"); end
        tests_run++;
        if (par_cnt != 64) begin tests_failed++; $display("[TB] FAIL p16_par_reads: got %0d, expected 64", par_cnt); end
        tests_run++;
        if (par_err != 0) begin tests_failed++; $display("[TB] FAIL p16_par_addr: got %0d bad, expected 0", par_err); end
        tests_run++;
        if (sao_err != 0) begin tests_failed++; $display("[TB] FAIL p16_sao: got %0d bad, expected 0", sao_err); end
        tests_run++;
        if (lcu_err != 0) begin tests_failed++; $display("[TB] FAIL p16_lcu_pos: got %0d bad, expected 0", lcu_err); end
        tests_run++;
        if (ord_err != 0 || en_cnt != 16384) begin
            tests_failed++;
            $display("[TB] FAIL p16_stream: got %0d pixels %0d bad, expected 16384 and 0", en_cnt, ord_err);
        end
    endtask

    task automatic test_back_to_back_stall();
        bit to;
        bit found;
        nlog_tb = 6;
        data_ff = 1'b0;
        clear_mon();
        pulse_start(2'd3);
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (bus.pix_rd && bus.pix_addr == 14'd164) begin found = 1'b1; break; end
        end
        tests_run++;
        if (!found) begin tests_failed++; $display("[TB] FAIL stall_find: read of pixel 100 not seen"); end
        @(posedge clk);
        #1 bus.busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests_run++;
            if (bus.in_en !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL stall_in_en%0d: got %b, expected 0", i, bus.in_en);
            end
        end
        @(posedge clk);
        #1 bus.busy = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.in_en !== 1'b1 || bus.din !== 8'd164) begin
            tests_failed++;
            $display("[TB] FAIL stall_hold: got en=%b din=%0d, expected en=1 din=164", bus.in_en, bus.din);
        end
        @(negedge clk);
        tests_run++;
        if (bus.in_en !== 1'b1 || bus.din !== 8'd165) begin
            tests_failed++;
            $display("[TB] FAIL stall_next: got en=%b din=%0d, expected en=1 din=165", bus.in_en, bus.din);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_until_done(20000, to);
        tests_run++;
        if (to) begin tests_failed++; $display("[TB] FAIL stall_timeout: done not seen within 20000 cycles"); end
        tests_run++;
        if (en_cnt != 16384) begin tests_failed++; $display("[TB] FAIL stall_count: got %0d, expected 16384", en_cnt); end
        tests_run++;
        if (ord_err != 0) begin tests_failed++; $display("[TB] FAIL stall_order: got %0d bad, expected 0", ord_err); end
        tests_run++;
        if (lcu_err != 0 || par_cnt != 4) begin
            tests_failed++;
            $display("[TB] FAIL cfg3_geometry: got %0d bad lcu, %0d par reads, expected 0 and 4", lcu_err, par_cnt);
        end
        tests_run++;
        if (done_cnt != 1) begin tests_failed++; $display("[TB] FAIL start_ignored_done: got %0d, expected 1", done_cnt); end
        tests_run++;
        if (en_busy_err != 0) begin tests_failed++; $display("[TB] FAIL stall_en_busy: got %0d, expected 0", en_busy_err); end
    endtask

    task automatic test_reset_mid();
        bit found;
        nlog_tb = 4;
        data_ff = 1'b0;
        clear_mon();
        pulse_start(2'd0);
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (en_cnt >= 3 * 256 + 20) begin found = 1'b1; break; end
        end
        tests_run++;
        if (!found || bus.lcu_x !== 3'd3) begin
            tests_failed++;
            $display("[TB] FAIL rmid_reach: got found=%b lcu_x=%0d, expected 1 and 3", found, bus.lcu_x);
        end
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if ({bus.pix_rd, bus.pix_addr, bus.par_rd, bus.par_addr, bus.in_en, bus.din, bus.sao_type, bus.sao_band_pos,
             bus.sao_eo_class, bus.sao_offset, bus.lcu_x, bus.lcu_y, bus.lcu_size, done, csum} !== 80'd0) begin
            tests_failed++;
            $display("[TB] FAIL rmid_outputs: got %h, expected 0",
                     {bus.pix_rd, bus.pix_addr, bus.par_rd, bus.par_addr, bus.in_en, bus.din, bus.sao_type,
                      bus.sao_band_pos, bus.sao_eo_class, bus.sao_offset, bus.lcu_x, bus.lcu_y, bus.lcu_size, done, csum});
        end
        @(negedge clk);
        reset = 1'b0;
        clear_mon();
        pulse_start(2'd0);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (en_cnt >= 4) begin found = 1'b1; break; end
        end
        tests_run++;
        if (!found) begin tests_failed++; $display("[TB] FAIL rmid_restart: no pixels after restart"); end
        tests_run++;
        if ({first_din[0], first_din[1], first_din[2], first_din[3]} !== 32'h00010203) begin
            tests_failed++;
            $display("[TB] FAIL rmid_first_pixels: got %h, expected 00010203",
                     {first_din[0], first_din[1], first_din[2], first_din[3]});
        end
        tests_run++;
        if (lcu_err != 0 || par_err != 0 || par_cnt != 1) begin
            tests_failed++;
            $display("[TB] FAIL rmid_lcu00: got lcu_err=%0d par_err=%0d par_reads=%0d, expected 0 0 1", lcu_err, par_err, par_cnt);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_csum();
        bit to;
        logic [15:0] exp_csum;
`ifdef STREAM_CSUM_EN
        exp_csum = 16'hC000;
`else
        exp_csum = 16'h0000;
`endif
        nlog_tb = 5;
        data_ff = 1'b1;
        clear_mon();
        pulse_start(2'd1);
        run_until_done(20000, to);
        tests_run++;
        if (to) begin tests_failed++; $display("[TB] FAIL csum_timeout: done not seen within 20000 cycles"); end
        tests_run++;
        if (en_cnt != 16384 || ord_err != 0 || lcu_err != 0) begin
            tests_failed++;
            $display("[TB] FAIL csum_stream: got %0d pixels, %0d bad, %0d bad lcu, expected 16384 0 0", en_cnt, ord_err, lcu_err);
        end
        tests_run++;
        if (csum !== exp_csum) begin tests_failed++; $display("[TB] FAIL csum_value: got %h, expected %h", csum, exp_csum); end
        data_ff = 1'b0;
    endtask

    initial begin
        start        = 1'b0;
        lcu_size_cfg = 2'd0;
        bus.busy     = 1'b0;
        test_reset();
        test_frame_64();
        test_params_16();
        test_back_to_back_stall();
        test_reset_mid();
        test_csum();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
